ysyx_22050535_idu_stage: RTL and testbench

Pipelined RISC-V instruction-decode stage between IFU and EXU. Accepts fetched {pc, inst} over a valid/ready handshake and decodes every RV32I/RV32E base format (R/I/S/B/U/J). Presents a registered decode bundle downstream with a 2-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`. Supersedes the purely combinational decoder: adds U/S immediates, register-count parametrisation, illegal detection, flush and back-pressure.

---
 rtl/ysyx_22050535_idu_stage_pkg.sv | 27 ++
 rtl/ysyx_22050535_imm_gen.sv | 29 ++
 rtl/ysyx_22050535_idu_stage.sv | 196 +++++++++++++++++++
 tb/tb_ysyx_22050535_idu_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050535_idu_stage_pkg.sv
// Shared decode definitions for the IDU stage: opcode constants, immediate
// formats and the default datapath width.
package ysyx_22050535_idu_stage_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_e;

endpackage

// File: rtl/ysyx_22050535_imm_gen.sv
// Combinational RV32 immediate generator; builds the 32-bit immediate for the
// selected format and sign-extends it from inst[31] to XLEN.
module ysyx_22050535_imm_gen
   import ysyx_22050535_idu_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [31:7]     inst,
   input  imm_type_e       imm_type,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (imm_type)
         IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm32 = {inst[31:12], 12'b0};
         IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/ysyx_22050535_idu_stage.sv
// RV32I/RV32E decode stage with a registered output and 2-entry skid buffer.
// Define YSYX_22050535_IDU_PERF_EN to add the perf_decoded/perf_stall counters.
module ysyx_22050535_idu_stage
   import ysyx_22050535_idu_stage_pkg::*;
#(
   parameter int XLEN       = XLEN_DEFAULT,
   parameter int REG_ADDR_W = 5,
   parameter int INST_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [INST_W-1:0]     in_inst,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_pc,
   output logic [INST_W-1:0]     out_inst,
   output logic [6:0]            out_opcode,
   output logic [2:0]            out_func3,
   output logic [6:0]            out_func7,
   output logic [REG_ADDR_W-1:0] out_rs1,
   output logic [REG_ADDR_W-1:0] out_rs2,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic                  out_rs1_en,
   output logic                  out_rs2_en,
   output logic                  out_rd_we,
   output logic [XLEN-1:0]       out_imm,
   output logic                  out_illegal
`ifdef YSYX_22050535_IDU_PERF_EN
   ,
   output logic [31:0]           perf_decoded,
   output logic [31:0]           perf_stall
`endif
);

   localparam int BW = XLEN + INST_W + XLEN + 4;

   imm_type_e       imm_type;
   logic            rs1_use, rs2_use, rd_use, op_bad, reg_bad;
   logic            dec_illegal, dec_rs1_en, dec_rs2_en, dec_rd_we;
   logic [XLEN-1:0] dec_imm;
   logic [BW-1:0]   dec_bundle;

   always_comb begin
      imm_type = IMM_NONE;
      rs1_use  = 1'b0;
      rs2_use  = 1'b0;
      rd_use   = 1'b0;
      op_bad   = 1'b0;
      case (in_inst[6:0])
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
            imm_type = IMM_I;
            rs1_use  = 1'b1;
            rd_use   = 1'b1;
         end
         OP_STORE: begin
            imm_type = IMM_S;
            rs1_use  = 1'b1;
            rs2_use  = 1'b1;
         end
         OP_BRANCH: begin
            imm_type = IMM_B;
            rs1_use  = 1'b1;
            rs2_use  = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            imm_type = IMM_U;
            rd_use   = 1'b1;
         end
         OP_JAL: begin
            imm_type = IMM_J;
            rd_use   = 1'b1;
         end
         OP_REG: begin
            rs1_use  = 1'b1;
            rs2_use  = 1'b1;
            rd_use   = 1'b1;
         end
         default: op_bad = 1'b1;
      endcase
      if (in_inst[1:0] != 2'b11) begin
         op_bad = 1'b1;
      end
   end

   // RV32E has only x0..x15: any referenced register with bit 4 set is illegal.
   generate
      if (REG_ADDR_W == 4) begin : g_rv32e
         assign reg_bad = (rs1_use & in_inst[19]) | (rs2_use & in_inst[24]) | (rd_use & in_inst[11]);
      end else begin : g_rv32i
         assign reg_bad = 1'b0;
      end
   endgenerate

   assign dec_illegal = op_bad | reg_bad;
   assign dec_rs1_en  = rs1_use & ~dec_illegal;
   assign dec_rs2_en  = rs2_use & ~dec_illegal;
   assign dec_rd_we   = rd_use & (in_inst[7 +: REG_ADDR_W] != '0) & ~dec_illegal;

   ysyx_22050535_imm_gen #(
      .XLEN(XLEN)
   ) u_imm_gen (
      .inst    (in_inst[31:7]),
      .imm_type(imm_type),
      .imm     (dec_imm)
   );

   assign dec_bundle = {in_pc, in_inst, dec_imm, dec_rs1_en, dec_rs2_en, dec_rd_we, dec_illegal};

   logic          main_valid_reg, main_valid_next;
   logic          skid_valid_reg, skid_valid_next;
   logic [BW-1:0] main_reg, main_next;
   logic [BW-1:0] skid_reg, skid_next;
   logic          accept, drain;

   // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
   assign in_ready  = ~skid_valid_reg;
   assign out_valid = main_valid_reg;
   assign accept    = in_valid & in_ready;
   assign drain     = main_valid_reg & out_ready;

   always_comb begin
      main_valid_next = main_valid_reg;
      skid_valid_next = skid_valid_reg;
      main_next       = main_reg;
      skid_next       = skid_reg;
      if (flush) begin
         main_valid_next = 1'b0;
         skid_valid_next = 1'b0;
      end else if (drain) begin
         if (skid_valid_reg) begin
            main_next       = skid_reg;
            skid_valid_next = 1'b0;
         end else if (accept) begin
            main_next       = dec_bundle;
         end else begin
            main_valid_next = 1'b0;
         end
      end else if (accept) begin
         if (main_valid_reg) begin
            skid_next       = dec_bundle;
            skid_valid_next = 1'b1;
         end else begin
            main_next       = dec_bundle;
            main_valid_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_reg <= 1'b0;
         skid_valid_reg <= 1'b0;
         main_reg       <= '0;
         skid_reg       <= '0;
      end else begin
         main_valid_reg <= main_valid_next;
         skid_valid_reg <= skid_valid_next;
         main_reg       <= main_next;
         skid_reg       <= skid_next;
      end
   end

   assign {out_pc, out_inst, out_imm, out_rs1_en, out_rs2_en, out_rd_we, out_illegal} = main_reg;
   assign out_opcode = out_inst[6:0];
   assign out_func3  = out_inst[14:12];
   assign out_func7  = out_inst[31:25];
   assign out_rs1    = out_inst[15 +: REG_ADDR_W];
   assign out_rs2    = out_inst[20 +: REG_ADDR_W];
   assign out_rd     = out_inst[7 +: REG_ADDR_W];

`ifdef YSYX_22050535_IDU_PERF_EN
   logic [31:0] perf_decoded_reg, perf_stall_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_decoded_reg <= '0;
         perf_stall_reg   <= '0;
      end else begin
         if (out_valid && out_ready) begin
            perf_decoded_reg <= perf_decoded_reg + 32'd1;
         end
         if (in_valid && !in_ready) begin
            perf_stall_reg <= perf_stall_reg + 32'd1;
         end
      end
   end

   assign perf_decoded = perf_decoded_reg;
   assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_ysyx_22050535_idu_stage.sv
// Directed bench for the IDU stage: an RV32I instance and an RV32E instance
// share the stimulus; expected values are hand-decoded constants.
module tb_ysyx_22050535_idu_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_inst = '0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, out_rs1_en, out_rs2_en, out_rd_we, out_illegal;
   logic [31:0] out_pc, out_inst, out_imm;
   logic [6:0]  out_opcode, out_func7;
   logic [2:0]  out_func3;
   logic [4:0]  out_rs1, out_rs2, out_rd;

   logic        e_in_ready, e_out_valid, e_rs1_en, e_rs2_en, e_rd_we, e_illegal;
   logic [31:0] e_pc, e_inst, e_imm;
   logic [6:0]  e_opcode, e_func7;
   logic [2:0]  e_func3;
   logic [3:0]  e_rs1, e_rs2, e_rd;

`ifdef YSYX_22050535_IDU_PERF_EN
   logic [31:0] perf_decoded, perf_stall, e_perf_decoded, e_perf_stall;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ysyx_22050535_idu_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_inst(out_inst), .out_opcode(out_opcode), .out_func3(out_func3),
      .out_func7(out_func7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_we(out_rd_we),
      .out_imm(out_imm), .out_illegal(out_illegal)
`ifdef YSYX_22050535_IDU_PERF_EN
      , .perf_decoded(perf_decoded), .perf_stall(perf_stall)
`endif
   );

   ysyx_22050535_idu_stage #(.REG_ADDR_W(4)) dut_e (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(e_in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(e_out_valid), .out_ready(out_ready),
      .out_pc(e_pc), .out_inst(e_inst), .out_opcode(e_opcode), .out_func3(e_func3),
      .out_func7(e_func7), .out_rs1(e_rs1), .out_rs2(e_rs2), .out_rd(e_rd),
      .out_rs1_en(e_rs1_en), .out_rs2_en(e_rs2_en), .out_rd_we(e_rd_we),
      .out_imm(e_imm), .out_illegal(e_illegal)
`ifdef YSYX_22050535_IDU_PERF_EN
      , .perf_decoded(e_perf_decoded), .perf_stall(e_perf_stall)
`endif
   );

   // Offer one instruction for one edge with out_ready high; bundle is visible afterwards.
   task automatic send(input logic [31:0] pc, input logic [31:0] inst);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_pc     = pc;
      in_inst   = inst;
      @(posedge clk); #1;
      in_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_inst !== 32'h0 || out_pc !== 32'h0 || out_imm !== 32'h0) begin failures++;
         $display("FAIL reset_fields got inst=%h pc=%h imm=%h exp=0", out_inst, out_pc, out_imm); end
   endtask

   task automatic test_decode_addi();
      send(32'h8000_0000, 32'h0050_0093);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
      checks++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0) begin failures++; $display("FAIL addi_regs got rd=%0d rs1=%0d exp rd=1 rs1=0", out_rd, out_rs1); end
      checks++; if (out_imm !== 32'h0000_0005) begin failures++; $display("FAIL addi_imm got=%h exp=00000005", out_imm); end
      checks++; if ({out_rd_we, out_rs1_en, out_rs2_en, out_illegal} !== 4'b1100) begin failures++;
         $display("FAIL addi_flags got we/rs1/rs2/ill=%b exp=1100", {out_rd_we, out_rs1_en, out_rs2_en, out_illegal}); end
      checks++; if (out_pc !== 32'h8000_0000 || out_opcode !== 7'h13) begin failures++; $display("FAIL addi_pc got pc=%h op=%h exp pc=80000000 op=13", out_pc, out_opcode); end
      checks++; if (e_illegal !== 1'b0 || e_rd_we !== 1'b1) begin failures++; $display("FAIL e_addi got ill=%b we=%b exp ill=0 we=1", e_illegal, e_rd_we); end
   endtask

   task automatic test_decode_lui();
      send(32'h8000_0004, 32'h1234_5137);
      checks++; if (out_imm !== 32'h1234_5000) begin failures++; $display("FAIL lui_imm got=%h exp=12345000", out_imm); end
      checks++; if (out_rd !== 5'd2 || out_rd_we !== 1'b1 || out_rs1_en !== 1'b0) begin failures++;
         $display("FAIL lui_regs got rd=%0d we=%b rs1_en=%b exp rd=2 we=1 rs1_en=0", out_rd, out_rd_we, out_rs1_en); end
   endtask

   task automatic test_decode_sw();
      send(32'h8000_0008, 32'hFE20_AE23);
      checks++; if (out_imm !== 32'hFFFF_FFFC) begin failures++; $display("FAIL sw_imm got=%h exp=fffffffc", out_imm); end
      checks++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_func3 !== 3'd2) begin failures++;
         $display("FAIL sw_fields got rs1=%0d rs2=%0d f3=%0d exp 1 2 2", out_rs1, out_rs2, out_func3); end
      checks++; if ({out_rd_we, out_rs1_en, out_rs2_en} !== 3'b011) begin failures++;
         $display("FAIL sw_flags got we/rs1/rs2=%b exp=011", {out_rd_we, out_rs1_en, out_rs2_en}); end
   endtask

   task automatic test_decode_jal();
      send(32'h8000_000C, 32'hFF9F_F06F);
      checks++; if (out_imm !== 32'hFFFF_FFF8) begin failures++; $display("FAIL jal_imm got=%h exp=fffffff8", out_imm); end
      checks++; if (out_rd_we !== 1'b0 || out_illegal !== 1'b0) begin failures++; $display("FAIL jal_flags got we=%b ill=%b exp 0 0", out_rd_we, out_illegal); end
   endtask

   task automatic test_decode_illegal();
      send(32'h8000_0010, 32'h0000_0000);
      checks++; if (out_illegal !== 1'b1 || out_rd_we !== 1'b0 || out_rs1_en !== 1'b0) begin failures++;
         $display("FAIL zero_illegal got ill=%b we=%b rs1_en=%b exp 1 0 0", out_illegal, out_rd_we, out_rs1_en); end
      checks++; if (out_imm !== 32'h0) begin failures++; $display("FAIL zero_imm got=%h exp=0", out_imm); end
      // addi x1,x31,0: rs1 = 31 is out of range only for the RV32E instance.
      send(32'h8000_0014, 32'h000F_8093);
      checks++; if (e_illegal !== 1'b1 || e_rd_we !== 1'b0 || e_rs1_en !== 1'b0) begin failures++;
         $display("FAIL e_rs1_range got ill=%b we=%b rs1_en=%b exp 1 0 0", e_illegal, e_rd_we, e_rs1_en); end
      checks++; if (out_illegal !== 1'b0 || out_rd_we !== 1'b1 || out_rs1 !== 5'd31) begin failures++;
         $display("FAIL i_rs1_31 got ill=%b we=%b rs1=%0d exp 0 1 31", out_illegal, out_rd_we, out_rs1); end
      // addi x16,x0,0: rd out of range for RV32E.
      send(32'h8000_0018, 32'h0000_0813);
      checks++; if (e_illegal !== 1'b1 || e_rd_we !== 1'b0) begin failures++; $display("FAIL e_rd_range got ill=%b we=%b exp 1 0", e_illegal, e_rd_we); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL decode_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] seq [4];
      int sent, recv, stalls;
`ifdef YSYX_22050535_IDU_PERF_EN
      logic [31:0] base_stall, base_dec;
      base_stall = perf_stall;
      base_dec   = perf_decoded;
`endif
      seq = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};
      sent = 0; recv = 0; stalls = 0;
      for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
         out_ready = (cyc >= 3);
         in_valid  = (sent < 4);
         in_inst   = (sent < 4) ? seq[sent] : 32'h0;
         in_pc     = 32'h100 + 32'(4 * sent);
         if (cyc == 2) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_low got=%b exp=0", in_ready); end
            checks++; if (out_valid !== 1'b1 || out_inst !== seq[0]) begin failures++;
               $display("FAIL b2b_hold got valid=%b inst=%h exp 1 %h", out_valid, out_inst, seq[0]); end
         end
         if (out_valid && out_ready) begin
            checks++; if (out_inst !== seq[recv] || out_pc !== 32'h100 + 32'(4 * recv)) begin failures++;
               $display("FAIL b2b_order got inst=%h pc=%h exp inst=%h pc=%h", out_inst, out_pc, seq[recv], 32'h100 + 32'(4 * recv)); end
            recv++;
         end
         if (in_valid && !in_ready) stalls++;
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++; if (recv !== 4 || sent !== 4) begin failures++; $display("FAIL b2b_count got recv=%0d sent=%0d exp 4 4", recv, sent); end
      checks++; if (stalls !== 2) begin failures++; $display("FAIL b2b_stalls got=%0d exp=2", stalls); end
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
         $display("FAIL b2b_no_dup got valid=%b in_ready=%b exp 0 1", out_valid, in_ready); end
`ifdef YSYX_22050535_IDU_PERF_EN
      checks++; if (perf_stall - base_stall !== 32'd2) begin failures++; $display("FAIL perf_stall got=%0d exp=2", perf_stall - base_stall); end
      checks++; if (perf_decoded - base_dec !== 32'd4) begin failures++; $display("FAIL perf_decoded got=%0d exp=4", perf_decoded - base_dec); end
`endif
   endtask

   task automatic test_flush();
`ifdef YSYX_22050535_IDU_PERF_EN
      logic [31:0] base_dec;
      base_dec = perf_decoded;
`endif
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'h0010_0093; in_pc = 32'h200;
      @(posedge clk); #1;
      in_inst = 32'h0020_0113; in_pc = 32'h204;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++;
         $display("FAIL flush_pre got valid=%b in_ready=%b exp 1 0", out_valid, in_ready); end
      flush = 1'b1; in_inst = 32'h0030_0193;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
         $display("FAIL flush_two got valid=%b in_ready=%b exp 0 1", out_valid, in_ready); end
      // Flush with in_ready high must still drop the offered instruction.
      flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0040_0213;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got=%b exp=0", out_valid); end
`ifdef YSYX_22050535_IDU_PERF_EN
      checks++; if (perf_decoded !== base_dec) begin failures++; $display("FAIL perf_flush got=%0d exp=%0d", perf_decoded, base_dec); end
`endif
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h300;
      @(posedge clk); #1;
      in_inst = 32'h0060_0113;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_inst !== 32'h0 || in_ready !== 1'b1) begin failures++;
         $display("FAIL async_reset got valid=%b inst=%h in_ready=%b exp 0 0 1", out_valid, out_inst, in_ready); end
      @(posedge clk); #1 rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
         $display("FAIL post_reset got valid=%b in_ready=%b exp 0 1", out_valid, in_ready); end
   endtask

   initial begin
      test_reset();
      test_decode_addi();
      test_decode_lui();
      test_decode_sw();
      test_decode_jal();
      test_decode_illegal();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
